// File: rtl/pep_ks_cmd_issuer_pkg.sv
// rtl/pep_ks_cmd_issuer_pkg.sv - shared types and pointer helpers for the KS input pool reader
package pep_ks_cmd_issuer_pkg;
  localparam int TOTAL_PBS_NB  = 32;
  localparam int BATCH_PBS_NB  = 16;
  localparam int LWE_K         = 12;
  localparam int TIMEOUT_CNT_W = 32;

  localparam int PID_W      = $clog2(TOTAL_PBS_NB);
  localparam int PID_WW     = $clog2(TOTAL_PBS_NB + 1);
  localparam int LWE_K_P1_W = $clog2(LWE_K + 1);
  localparam int SPAN_W     = PID_WW + 1;

  typedef logic [PID_W-1:0]         pid_t;
  typedef logic [PID_WW-1:0]        elt_t;
  typedef logic [SPAN_W-1:0]        span_t;
  typedef logic [LWE_K_P1_W-1:0]    loop_t;
  typedef logic [TIMEOUT_CNT_W-1:0] tcnt_t;

  localparam elt_t  BATCH_ELT = elt_t'(BATCH_PBS_NB);
  localparam span_t TOTAL_SPAN = span_t'(TOTAL_PBS_NB);
  localparam loop_t LOOP_LAST = loop_t'(LWE_K);

  typedef struct packed {
    logic c;
    pid_t pt;
  } pointer_t;

  typedef struct packed {
    logic     ks_loop_c;
    loop_t    ks_loop;
    pointer_t wp;
    pointer_t rp;
  } ks_cmd_t;

  localparam int KS_CMD_W = $bits(ks_cmd_t);

  typedef struct packed {
    logic ks_wp_ovf;
  } pep_seq_error_t;

  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_FULL, CAUSE_FLUSH, CAUSE_TIMEOUT} start_cause_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_DONE} issue_state_e;

  // Raw wp-rp distance one bit wider than needed; an underflow lands far above TOTAL_PBS_NB.
  function automatic span_t pt_span(pointer_t wp, pointer_t rp);
    span_t base;
    base = (wp.c != rp.c) ? TOTAL_SPAN : '0;
    return base + span_t'(wp.pt) - span_t'(rp.pt);
  endfunction

  function automatic logic pt_ovf(pointer_t wp, pointer_t rp);
    return pt_span(wp, rp) > TOTAL_SPAN;
  endfunction

  function automatic elt_t pt_elt_nb(pointer_t wp, pointer_t rp);
    return elt_t'(pt_span(wp, rp));
  endfunction

  function automatic pointer_t pt_add(pointer_t p, elt_t n);
    span_t    sum;
    pointer_t r;
    sum = span_t'(p.pt) + span_t'(n);
    if (sum >= TOTAL_SPAN) begin
      r.c  = ~p.c;
      r.pt = pid_t'(sum - TOTAL_SPAN);
    end else begin
      r.c  = p.c;
      r.pt = pid_t'(sum);
    end
    return r;
  endfunction
endpackage

// File: rtl/pep_ks_cmd_issuer_batch_timer.sv
// rtl/pep_ks_cmd_issuer_batch_timer.sv - idle timeout counter and batch start-cause encoder
module pep_ks_batch_timer
  import pep_ks_cmd_issuer_pkg::*;
(
  input  logic                     clk,
  input  logic                     s_rst_n,
  input  logic                     idle,
  input  logic [PID_WW-1:0]        elt_nb,
  input  logic                     flush,
  input  logic [TIMEOUT_CNT_W-1:0] cfg_timeout,
  output start_cause_e             cause
);
  tcnt_t tcnt;
  logic  pending;
  logic  tmo_hit;

  assign pending = idle && (elt_nb != '0);
  assign tmo_hit = pending && (cfg_timeout != '0) && (tcnt == cfg_timeout - tcnt_t'(1));

  // A full pool wins over flush, which wins over the timeout.
  always_comb begin
    cause = CAUSE_NONE;
    if (pending) begin
      if (elt_nb >= BATCH_ELT)
        cause = CAUSE_FULL;
      else if (flush)
        cause = CAUSE_FLUSH;
      else if (tmo_hit)
        cause = CAUSE_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n)
      tcnt <= '0;
    else if (!pending || (cause != CAUSE_NONE))
      tcnt <= '0;
    else
      tcnt <= tcnt + tcnt_t'(1);
  end
endmodule

// File: rtl/pep_ks_cmd_issuer.sv
// rtl/pep_ks_cmd_issuer.sv - KS input pool reader: batches pending PIDs and issues keyswitch commands
module pep_ks_cmd_issuer
  import pep_ks_cmd_issuer_pkg::*;
(
  input  logic                     clk,
  input  logic                     s_rst_n,
  input  logic [PID_W:0]           wp,
  input  logic                     flush,
  input  logic [TIMEOUT_CNT_W-1:0] cfg_timeout,
  output logic [KS_CMD_W-1:0]      ks_cmd,
  output logic                     ks_cmd_vld,
  input  logic                     ks_cmd_rdy,
  input  logic                     ks_done,
  output logic [PID_W:0]           rp,
  output logic                     error_wp_ovf,
  output logic                     batch_inc,
  output logic                     timeout_inc
);
  issue_state_e   state;
  pointer_t       wp_r, wp_q, rp_r, wp_b;
  loop_t          ks_loop;
  logic           ks_loop_c;
  pep_seq_error_t err;
  start_cause_e   cause;
  ks_cmd_t        cmd;

  logic ovf_now, ovf_prev, wp_shrink;
  elt_t elt_now, elt_prev, elt_eff, bsz;

  // Both occupancies use the current rp so only writer motion is judged.
  assign ovf_now   = pt_ovf(wp_r, rp_r);
  assign ovf_prev  = pt_ovf(wp_q, rp_r);
  assign elt_now   = pt_elt_nb(wp_r, rp_r);
  assign elt_prev  = pt_elt_nb(wp_q, rp_r);
  assign wp_shrink = !ovf_now && !ovf_prev && (elt_now < elt_prev) && (state != ST_WAIT_DONE);
  assign elt_eff   = ovf_now ? '0 : elt_now;
  assign bsz       = (elt_eff >= BATCH_ELT) ? BATCH_ELT : elt_eff;

  pep_ks_batch_timer u_timer (
    .clk         (clk),
    .s_rst_n     (s_rst_n),
    .idle        (state == ST_IDLE),
    .elt_nb      (elt_eff),
    .flush       (flush),
    .cfg_timeout (cfg_timeout),
    .cause       (cause)
  );

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wp_r <= '0;
      wp_q <= '0;
      err  <= '0;
    end else begin
      wp_r          <= wp;
      wp_q          <= wp_r;
      err.ks_wp_ovf <= (ovf_now && !ovf_prev) || wp_shrink;
    end
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state       <= ST_IDLE;
      rp_r        <= '0;
      wp_b        <= '0;
      ks_loop     <= '0;
      ks_loop_c   <= 1'b0;
      ks_cmd_vld  <= 1'b0;
      batch_inc   <= 1'b0;
      timeout_inc <= 1'b0;
    end else begin
      batch_inc   <= 1'b0;
      timeout_inc <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cause != CAUSE_NONE) begin
            wp_b        <= pt_add(rp_r, bsz);
            ks_loop     <= '0;
            ks_cmd_vld  <= 1'b1;
            batch_inc   <= 1'b1;
            timeout_inc <= (cause == CAUSE_TIMEOUT);
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ks_cmd_rdy) begin
            if (ks_loop == LOOP_LAST) begin
              ks_cmd_vld <= 1'b0;
              state      <= ST_WAIT_DONE;
            end else begin
              ks_loop <= ks_loop + loop_t'(1);
            end
          end
        end
        ST_WAIT_DONE: begin
          if (ks_done) begin
            rp_r      <= wp_b;
            ks_loop_c <= ~ks_loop_c;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd = '{ks_loop_c: ks_loop_c, ks_loop: ks_loop, wp: wp_b, rp: rp_r};
  assign ks_cmd       = cmd;
  assign rp           = rp_r;
  assign error_wp_ovf = err.ks_wp_ovf;
endmodule

// File: doc/pep_ks_cmd_issuer.md
Name: pep_ks_cmd_issuer

Overview:
- Reader end of the KS input pool: the load-BLWE side advances the pool write pointer; this block owns the read pointer.
- Groups pending PIDs into batches of up to BATCH_PBS_NB and issues one ks_cmd_t per ks_loop column (0..LWE_K) to the keyswitch.
- Waits for keyswitch completion of each batch, then releases the batch's slots back to the writer by advancing the read pointer.

Parameters:
- TOTAL_PBS_NB, 32: pool slots; power of 2 not required.
- BATCH_PBS_NB, 16: maximum PIDs per KS batch; must be ≤ TOTAL_PBS_NB.
- LWE_K, 12: LWE dimension; ks_loop runs 0..LWE_K inclusive.
- TIMEOUT_CNT_W, 32: width of the timeout counter.

Ports:
- clk  in  1  clock.
- s_rst_n  in  1  asynchronous active-low reset.
- wp  in  PID_W+1  writer pointer (pointer_t: c, pt); sampled every cycle.
- flush  in  1  pulse: issue a partial batch immediately if the pool is not empty.
- cfg_timeout  in  TIMEOUT_CNT_W  idle cycles before a partial batch is issued; 0 disables.
- ks_cmd  out  KS_CMD_W  {ks_loop_c, ks_loop, wp, rp}.
- ks_cmd_vld  out  1  command valid.
- ks_cmd_rdy  in  1  keyswitch accepts the command.
- ks_done  in  1  pulse: current batch fully keyswitched.
- rp  out  PID_W+1  read pointer returned to the writer.
- error_wp_ovf  out  1  one-cycle pulse on illegal writer pointer.
- batch_inc, timeout_inc  out  1  counter increment pulses.

Behaviour:
- Reset values: rp=0, ks_cmd_vld=0, ks_loop=0, ks_loop_c=0, all pulses 0, state IDLE, timeout counter 0.
- Pool occupancy: elt_nb = pt_elt_nb(wp, rp), width PID_WW.
  - Equal pt with differing c means full (TOTAL_PBS_NB).
  - elt_nb > TOTAL_PBS_NB cannot be encoded. A writer pointer that decreases elt_nb while not in WAIT_DONE, or that implies overfill, raises error_wp_ovf. State is not altered.
- Batch size: bsz = min(elt_nb, BATCH_PBS_NB).
- Batch end pointer wp_b = rp + bsz:
  - if rp.pt + bsz ≥ TOTAL_PBS_NB, pt wraps (subtract TOTAL_PBS_NB) and c toggles;
  - otherwise c is unchanged.
- FSM IDLE:
  - Start condition: elt_nb ≥ BATCH_PBS_NB, or (elt_nb>0 and flush), or (elt_nb>0 and cfg_timeout≠0 and tcnt == cfg_timeout-1).
  - tcnt increments while elt_nb>0 and resets to 0 when elt_nb==0 or on batch start.
  - On start: latch wp_b and ks_loop=0, pulse batch_inc (and timeout_inc if the timeout was the cause), go ISSUE.
  - Flush with an empty pool is ignored.
- FSM ISSUE:
  - ks_cmd_vld=1 with ks_cmd = {ks_loop_c, ks_loop, wp_b, rp}.
  - Fields are stable while vld && !rdy.
  - On vld&&rdy: if ks_loop==LWE_K go WAIT_DONE with vld=0 next cycle; else ks_loop++ with vld held, giving back-to-back issue at one command per cycle.
  - LWE_K+1 commands per batch, latency IDLE→first vld is 1 cycle.
- FSM WAIT_DONE:
  - On ks_done: rp ← wp_b, ks_loop_c toggles, go IDLE.
  - New rp is visible the cycle after ks_done; the next batch can start 1 cycle after that.
- Boundary rules:
  - ks_done outside WAIT_DONE is ignored.
  - wp moving during ISSUE/WAIT_DONE does not change the in-flight batch.
  - flush during ISSUE/WAIT_DONE is dropped (not queued).
  - Reset mid-batch returns to reset values; the writer must be reset together.

Decomposition:
- Shared package: pointer_t, ks_cmd_t, pt_elt_nb and a new pt_add(pointer_t, n) function, PID_W/PID_WW, LWE_K_P1_W, TIMEOUT_CNT_W.
- Error struct pep_seq_error_t gains ks_wp_ovf.
- One natural sub-module: pep_ks_batch_timer (timeout counter plus start-cause encoding).

Test Plan:
- Full batch: wp {0,16} → one batch_inc; 13 commands ks_loop 0..12 with rp={0,0}, wp={0,16}, ks_loop_c=0; ks_done → rp={0,16}, ks_loop_c=1.
- Partial via timeout: cfg_timeout=5, wp {0,3} → first vld exactly 6 cycles later; wp_b={0,3}; timeout_inc=1.
- Wrap: rp={0,24}, wp={1,8} (elt_nb 16) → wp_b={1,8}; after ks_done rp={1,8}.
- Backpressure: ks_cmd_rdy low for 4 cycles at ks_loop=5 → ks_cmd stable, no skipped or duplicated ks_loop values.
- Flush with elt_nb=0 → no command; flush with elt_nb=1 → one batch wp_b=rp+1; stray ks_done in IDLE → no rp change.
- Illegal wp: rp={0,0}, wp={1,4} (elt_nb 36) → error_wp_ovf pulse, no batch issued; assert s_rst_n mid-ISSUE → vld=0, rp=0 immediately.
